// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined adder: chunk sizing, payload flags, parameter legality.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pipelined_adder_pkg;

   // Carry/overflow flags that travel with every stage payload.
   typedef struct packed {
      logic carry;   // carry out of the most recently computed chunk
      logic ovf;     // signed overflow of the most recently computed chunk
   } stage_flags_t;

   // Bits per chunk; one chunk is added in each pipeline stage.
   function automatic int chunk_w(input int width, input int stages);
      return width / stages;
   endfunction

   // Flattened payload width: partial sum, operand A, operand B, flags.
   function automatic int pay_w(input int width);
      return 3 * width + $bits(stage_flags_t);
   endfunction

   // A legal configuration splits WIDTH into STAGES equal, non-empty chunks.
   function automatic bit params_ok(input int width, input int stages);
      return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for the pipelined adder; SUB exists only with PIPELINED_ADDER_SUB_EN.
// Latency: n/a (wires only).
// Backpressure: IN_READY/OUT_READY carry valid-ready flow control in each direction.
interface pipelined_adder_if #(
   parameter int WIDTH = 16
);
   logic             IN_VALID;
   logic             IN_READY;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             CIN;
`ifdef PIPELINED_ADDER_SUB_EN
   logic             SUB;
`endif
   logic             OUT_VALID;
   logic             OUT_READY;
   logic [WIDTH-1:0] S;
   logic             COUT;
   logic             OVF;

   // Upstream/downstream agent side.
   modport master (
      output IN_VALID, A, B, CIN,
`ifdef PIPELINED_ADDER_SUB_EN
      output SUB,
`endif
      output OUT_READY,
      input  IN_READY, OUT_VALID, S, COUT, OVF
   );

   // Adder side.
   modport slave (
      input  IN_VALID, A, B, CIN,
`ifdef PIPELINED_ADDER_SUB_EN
      input  SUB,
`endif
      input  OUT_READY,
      output IN_READY, OUT_VALID, S, COUT, OVF
   );
endinterface

// File: rtl/pipelined_adder_stage.sv
// One pipeline stage: adds chunk IDX of the carried operands plus the incoming carry and registers it.
// Latency: 1 cycle.
// Backpressure: holds its payload while full and downstream not ready; o_rdy = !valid || i_rdy.
module adder_stage
   import pipelined_adder_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4,
   parameter int IDX    = 0,
   parameter int PAY_W  = pay_w(WIDTH)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_vld,
   output logic             o_rdy,
   input  logic [PAY_W-1:0] i_pay,
   output logic             o_vld,
   input  logic             i_rdy,
   output logic [PAY_W-1:0] o_pay
);
   localparam int CHUNK = chunk_w(WIDTH, STAGES);
   localparam int LO    = IDX * CHUNK;
   localparam int MSB   = LO + CHUNK - 1;

   // Sum keeps the already-computed low chunks; opa/opb keep the operands so upper chunks reach later stages.
   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic [WIDTH-1:0] opa;
      logic [WIDTH-1:0] opb;
      stage_flags_t     flg;
   } payload_t;

   payload_t       w_in;
   payload_t       w_nxt;
   payload_t       r_pay;
   logic [CHUNK:0] w_add;
   logic           r_vld;

   assign w_in = i_pay;

   // Chunk add; overflow uses carry-into-MSB = a^b^s at the chunk MSB, XORed with carry out.
   always_comb begin
      w_nxt                = w_in;
      w_add                = {1'b0, w_in.opa[LO +: CHUNK]} + {1'b0, w_in.opb[LO +: CHUNK]}
                           + {{CHUNK{1'b0}}, w_in.flg.carry};
      w_nxt.sum[LO +: CHUNK] = w_add[CHUNK-1:0];
      w_nxt.flg.carry      = w_add[CHUNK];
      w_nxt.flg.ovf        = w_in.opa[MSB] ^ w_in.opb[MSB] ^ w_add[CHUNK-1] ^ w_add[CHUNK];
   end

   assign o_rdy = !r_vld || i_rdy;

   // Stage register: load when empty or draining; reset discards whatever is in flight.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_vld <= 1'b0;
         r_pay <= '0;
      end else if (o_rdy) begin
         r_vld <= i_vld;
         if (i_vld) begin
            r_pay <= w_nxt;
         end
      end
   end

   assign o_vld = r_vld;
   assign o_pay = r_pay;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder, one WIDTH/STAGES chunk per stage; PIPELINED_ADDER_SUB_EN adds a SUB input.
// Latency: STAGES cycles from input transfer to OUT_VALID; one result per cycle sustained.
// Backpressure: OUT_READY low freezes outputs, pipe fills, IN_READY drops when all STAGES are full.
module pipelined_adder
   import pipelined_adder_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   pipelined_adder_if.slave bus
);
   localparam int PAY_W = pay_w(WIDTH);

   if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
      $error("pipelined_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
   end

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic [WIDTH-1:0] opa;
      logic [WIDTH-1:0] opb;
      stage_flags_t     flg;
   } payload_t;

   logic [STAGES:0] w_vld;
   logic [STAGES:0] w_rdy;
   logic [PAY_W-1:0] w_pay [STAGES+1];
   payload_t         w_src;
   payload_t         w_out;
   logic [2*WIDTH-1:0] w_unused_ops;

   // Entry payload: subtraction is folded in here as A + ~B + 1 so the stages only ever add.
   always_comb begin
      w_src           = '0;
      w_src.opa       = bus.A;
      w_src.opb       = bus.B;
      w_src.flg.carry = bus.CIN;
`ifdef PIPELINED_ADDER_SUB_EN
      if (bus.SUB) begin
         w_src.opb       = ~bus.B;
         w_src.flg.carry = 1'b1;
      end
`endif
   end

   assign w_vld[0]      = bus.IN_VALID;
   assign w_pay[0]      = w_src;
   assign bus.IN_READY  = w_rdy[0];
   assign w_rdy[STAGES] = bus.OUT_READY;

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      adder_stage #(
         .WIDTH  (WIDTH),
         .STAGES (STAGES),
         .IDX    (g),
         .PAY_W  (PAY_W)
      ) u_stage (
         .i_clk   (CLK),
         .i_rst_n (RST_N),
         .i_vld   (w_vld[g]),
         .o_rdy   (w_rdy[g]),
         .i_pay   (w_pay[g]),
         .o_vld   (w_vld[g+1]),
         .i_rdy   (w_rdy[g+1]),
         .o_pay   (w_pay[g+1])
      );
   end

   // Last stage register drives the result directly; the carried operands are dead by then.
   assign w_out         = w_pay[STAGES];
   assign bus.OUT_VALID = w_vld[STAGES];
   assign bus.S         = w_out.sum;
   assign bus.COUT      = w_out.flg.carry;
   assign bus.OVF       = w_out.flg.ovf;
   assign w_unused_ops  = {w_out.opa, w_out.opb};

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=16, STAGES=4).
// Inputs change 1ns after the rising edge; the monitor samples on the falling edge.
// Expected results come from a plain 17-bit add model, queued on input transfer.
module tb_pipelined_adder;
   localparam int W  = 16;
   localparam int ST = 4;

   typedef struct {
      logic [W-1:0] s;
      logic         cout;
      logic         ovf;
      int           acc;
      bit           lat;
   } exp_t;

   logic clk;
   logic rst_n;
   pipelined_adder_if #(.WIDTH(W)) bus();

   pipelined_adder #(.WIDTH(W), .STAGES(ST)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   exp_t q[$];
   logic tb_sub   = 1'b0;
   bit   cur_lat  = 1'b0;
   int   phase    = 0;   // 0 directed, 1 streaming, 2 backpressure
   int   stream_pops = 0;
   int   last_pop = 0;
   int   bp_low   = 0;
   bit   prev_stall = 1'b0;
   logic [W-1:0] prev_s;
   logic prev_cout, prev_ovf;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub);
      exp_t         e;
      logic [W:0]   t;
      logic [W-1:0] bb;
      logic         c;
      bb     = sub ? ~b : b;
      c      = sub ? 1'b1 : cin;
      t      = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
      e.s    = t[W-1:0];
      e.cout = t[W];
      e.ovf  = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
      e.acc  = 0;
      e.lat  = 1'b0;
      return e;
   endfunction

   always @(posedge clk) cyc++;

   // Monitor: decides the transfers that the next rising edge will perform.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         q.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_s", bus.S, prev_s);
            chk("hold_cout", bus.COUT, prev_cout);
            chk("hold_ovf", bus.OVF, prev_ovf);
         end
         if (phase == 1) chk("stream_in_rdy", bus.IN_READY, 1);
         if (phase == 2 && !bus.IN_READY) begin
            bp_low++;
            chk("bp_inflight", q.size(), ST);
         end
         if (bus.OUT_VALID && bus.OUT_READY) begin
            if (q.size() == 0) begin
               chk("spurious_out", 1, 0);
            end else begin
               e = q.pop_front();
               chk("s", bus.S, e.s);
               chk("cout", bus.COUT, e.cout);
               chk("ovf", bus.OVF, e.ovf);
               if (e.lat) chk("latency", cyc - e.acc, ST);
               if (phase == 1) begin
                  if (stream_pops > 0) chk("stream_gap", cyc - last_pop, 1);
                  stream_pops++;
               end
               last_pop = cyc;
            end
         end
         if (bus.IN_VALID && bus.IN_READY) begin
            e     = model(bus.A, bus.B, bus.CIN, tb_sub);
            e.acc = cyc;
            e.lat = cur_lat;
            q.push_back(e);
         end
         prev_stall = bus.OUT_VALID && !bus.OUT_READY;
         prev_s     = bus.S;
         prev_cout  = bus.COUT;
         prev_ovf   = bus.OVF;
      end
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, input bit lat);
      bit acc;
      bus.A        = a;
      bus.B        = b;
      bus.CIN      = cin;
      tb_sub       = sub;
`ifdef PIPELINED_ADDER_SUB_EN
      bus.SUB      = sub;
`endif
      cur_lat      = lat;
      bus.IN_VALID = 1'b1;
      acc          = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         acc = bus.IN_READY && rst_n;
         @(posedge clk);
         #1;
         if (acc) break;
      end
      if (!acc) chk("send_timeout", 0, 1);
   endtask

   task automatic idle();
      bus.IN_VALID = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 100; i++) begin
         if (q.size() == 0) break;
         @(posedge clk);
         #1;
      end
      chk(tag, q.size(), 0);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.IN_VALID  = 1'b0;
      bus.A         = '0;
      bus.B         = '0;
      bus.CIN       = 1'b0;
`ifdef PIPELINED_ADDER_SUB_EN
      bus.SUB       = 1'b0;
`endif
      bus.OUT_READY = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", bus.OUT_VALID, 0);
      chk("rst_s", bus.S, 0);
      chk("rst_cout", bus.COUT, 0);
      chk("rst_ovf", bus.OVF, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", bus.IN_READY, 1);
      @(posedge clk);
      #1;

      // Directed: carry ripple through all chunks, signed overflow, carry-in.
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1); idle(); drain("drain_carry");
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1); idle(); drain("drain_ovf");
      send(16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1); idle(); drain("drain_cin");
      send(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1); idle(); drain("drain_negovf");
`ifdef PIPELINED_ADDER_SUB_EN
      send(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1); idle(); drain("drain_sub1");
      send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1); idle(); drain("drain_sub2");
      send(16'h1234, 16'h1234, 1'b0, 1'b1, 1'b1); idle(); drain("drain_sub3");
`endif

      // Streaming: 8 back-to-back random pairs with downstream always ready.
      phase = 1;
      for (int i = 0; i < 8; i++)
         send(W'($urandom()), W'($urandom()), 1'($urandom()), 1'b0, 1'b1);
      idle();
      drain("drain_stream");
      phase = 0;
      chk("stream_count", stream_pops, 8);

      // Backpressure: downstream stalls for 6 cycles mid-stream.
      phase = 2;
      fork
         begin
            for (int i = 0; i < 12; i++)
               send(W'($urandom()), W'($urandom()), 1'($urandom()), 1'b0, 1'b0);
            idle();
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            bus.OUT_READY = 1'b0;
            repeat (6) @(posedge clk);
            #1;
            bus.OUT_READY = 1'b1;
         end
      join
      drain("drain_bp");
      phase = 0;
      chk("bp_in_ready_dropped", (bp_low > 0) ? 1 : 0, 1);

      // Reset with three transactions in flight: they must vanish.
      for (int i = 0; i < 3; i++)
         send(W'($urandom()), W'($urandom()), 1'b0, 1'b0, 1'b0);
      idle();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_out_valid", bus.OUT_VALID, 0);
      chk("midrst_s", bus.S, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", bus.IN_READY, 1);
      repeat (10) @(posedge clk);
      #1;
      send(16'hABCD, 16'h1111, 1'b1, 1'b0, 1'b1); idle(); drain("drain_post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
